addsub_result_collector: RTL and testbench

ADDSUB_RESULT_COLLECTOR -- requirements
Module: addsub_result_collector

---
 rtl/addsub_pkg.sv | 31 +++
 rtl/addsub_fifo.sv | 63 ++++++
 rtl/addsub_result_collector.sv | 102 ++++++++++
 tb/tb_addsub_result_collector.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the add/subtract result collector.
// Flag bits are only stored when the design is built with ADDSUB_FLAGS_EN.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int FLAG_ZERO   = 0;
  localparam int FLAG_BORROW = 1;

  localparam int ENTRY_W_NOFLAGS = 6;
  localparam int ENTRY_W_FLAGS   = 8;

  function automatic logic [1:0] entry_flags(input logic [3:0] sum,
                                             input logic       cout,
                                             input logic       op);
    logic [1:0] f;
    f              = 2'b00;
    f[FLAG_ZERO]   = (sum == 4'd0);
    f[FLAG_BORROW] = (op == OP_SUB) && !cout;
    return f;
  endfunction

  // Subtract results drop the carry: it only signals "no borrow" there.
  function automatic logic [4:0] add_value(input logic [3:0] sum,
                                           input logic       cout,
                                           input logic       op);
    return (op == OP_SUB) ? {1'b0, sum} : {cout, sum};
  endfunction

endpackage

// File: rtl/addsub_fifo.sv
// Generic synchronous FIFO, registered storage, no write-to-read bypass.
// DEPTH must be a power of two so pointers wrap by natural overflow.
module addsub_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == {CNT_W{1'b0}});
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign rdata_o   = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = push_ok_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/addsub_result_collector.sv
// Queues adder/subtractor results and keeps a running accumulation and count.
// Define ADDSUB_FLAGS_EN to store {borrow, zero} per entry on out_flags.
module addsub_result_collector
  import addsub_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sum,
  input  logic             in_cout,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_sum,
  output logic             out_cout,
  output logic             out_op,
  output logic [1:0]       out_flags,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] acc,
  output logic             acc_ovf,
  output logic [7:0]       res_cnt
);

`ifdef ADDSUB_FLAGS_EN
  localparam int ENTRY_W = ENTRY_W_FLAGS;
`else
  localparam int ENTRY_W = ENTRY_W_NOFLAGS;
`endif

  logic [ENTRY_W-1:0] wr_entry_s, rd_entry_s;
  logic               full_s, empty_s, push_s, pop_s;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_base_s, add_ext_s;
  logic [ACC_W:0]     acc_sum_s;
  logic               acc_ovf_q, acc_ovf_d;
  logic [7:0]         res_cnt_q, res_cnt_d, cnt_base_s;

  assign in_ready  = !full_s;
  assign out_valid = !empty_s;
  assign push_s    = in_valid && !full_s;
  assign pop_s     = out_ready && !empty_s;

`ifdef ADDSUB_FLAGS_EN
  assign wr_entry_s = {entry_flags(in_sum, in_cout, in_op), in_op, in_cout, in_sum};
  assign out_flags  = rd_entry_s[7:6];
`else
  assign wr_entry_s = {in_op, in_cout, in_sum};
  assign out_flags  = 2'b00;
`endif
  assign out_sum  = rd_entry_s[3:0];
  assign out_cout = rd_entry_s[4];
  assign out_op   = rd_entry_s[5];

  addsub_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (wr_entry_s),
    .rdata_o (rd_entry_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // A clear coinciding with a push restarts the totals from that push.
  always_comb begin
    add_ext_s  = {{(ACC_W-5){1'b0}}, add_value(in_sum, in_cout, in_op)};
    acc_base_s = acc_clr ? {ACC_W{1'b0}} : acc_q;
    cnt_base_s = acc_clr ? 8'd0 : res_cnt_q;
    acc_sum_s  = {1'b0, acc_base_s} + {1'b0, add_ext_s};
    if (push_s) begin
      acc_d     = acc_sum_s[ACC_W-1:0];
      acc_ovf_d = (acc_clr ? 1'b0 : acc_ovf_q) | acc_sum_s[ACC_W];
      res_cnt_d = (cnt_base_s == 8'd255) ? cnt_base_s : cnt_base_s + 8'd1;
    end else begin
      acc_d     = acc_base_s;
      acc_ovf_d = acc_clr ? 1'b0 : acc_ovf_q;
      res_cnt_d = cnt_base_s;
    end
  end

  // Accumulator, sticky overflow and result counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= {ACC_W{1'b0}};
      acc_ovf_q <= 1'b0;
      res_cnt_q <= 8'd0;
    end else begin
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      res_cnt_q <= res_cnt_d;
    end
  end

  assign acc     = acc_q;
  assign acc_ovf = acc_ovf_q;
  assign res_cnt = res_cnt_q;

endmodule

// File: tb/tb_addsub_result_collector.sv
// Scoreboard bench: directed scenarios then random traffic against a queue/integer model.
module tb_addsub_result_collector;

  localparam int DEPTH = 4;
  localparam int ACC_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_sum = 4'd0;
  logic             in_cout = 1'b0;
  logic             in_op = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       out_sum;
  logic             out_cout;
  logic             out_op;
  logic [1:0]       out_flags;
  logic             acc_clr = 1'b0;
  logic [ACC_W-1:0] acc;
  logic             acc_ovf;
  logic [7:0]       res_cnt;

  addsub_result_collector #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_op    (out_op),
    .out_flags (out_flags),
    .acc_clr   (acc_clr),
    .acc       (acc),
    .acc_ovf   (acc_ovf),
    .res_cnt   (res_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sum;
    logic       cout;
    logic       op;
    logic [1:0] flags;
  } exp_t;

  typedef struct {
    int acc;
    bit ovf;
    int cnt;
  } tot_t;

  exp_t sb_q[$];
  tot_t m_tot;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_flags(input logic [3:0] s, input logic c, input logic o);
`ifdef ADDSUB_FLAGS_EN
    return {(o == 1'b1) && (c == 1'b0), s == 4'd0};
`else
    return 2'b00;
`endif
  endfunction

  // Reference totals: plain integer arithmetic on what the result means.
  function automatic tot_t next_tot(input tot_t t, input bit clr, input bit push, input int val);
    tot_t n;
    n = clr ? '{0, 1'b0, 0} : t;
    if (push) begin
      n.acc = n.acc + val;
      if (n.acc >= (1 << ACC_W)) begin
        n.acc = n.acc - (1 << ACC_W);
        n.ovf = 1'b1;
      end
      if (n.cnt < 255) n.cnt = n.cnt + 1;
    end
    return n;
  endfunction

  // Tracker: records accepted pushes into the scoreboard at the clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q.delete();
      m_tot <= '{0, 1'b0, 0};
    end else begin
      if (in_valid && in_ready)
        sb_q.push_back('{in_sum, in_cout, in_op, exp_flags(in_sum, in_cout, in_op)});
      m_tot <= next_tot(m_tot, acc_clr, in_valid && in_ready,
                        in_op ? int'(in_sum) : int'(in_cout) * 16 + int'(in_sum));
    end
  end

  // Monitor: compares head/handshake/totals mid-cycle and pops on consumption.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", in_ready, sb_q.size() < DEPTH);
      check("out_valid", out_valid, sb_q.size() != 0);
      if (out_valid && sb_q.size() != 0) begin
        check("head", {out_op, out_cout, out_sum, out_flags},
              {sb_q[0].op, sb_q[0].cout, sb_q[0].sum, sb_q[0].flags});
        if (out_ready) void'(sb_q.pop_front());
      end
      check("acc", acc, m_tot.acc);
      check("acc_ovf", acc_ovf, m_tot.ovf);
      check("res_cnt", res_cnt, m_tot.cnt);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [3:0] s, input logic c, input logic o,
                      input logic rdy, input logic clr);
    in_valid  = 1'b1;
    in_sum    = s;
    in_cout   = c;
    in_op     = o;
    out_ready = rdy;
    acc_clr   = clr;
    tick(1);
    in_valid  = 1'b0;
    acc_clr   = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_acc", acc, 0);
    check("rst_cnt", res_cnt, 0);
    check("rst_ovf", acc_ovf, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("rst_in_ready", in_ready, 1);

    // 14-12 subtract result
    push(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0);
    check("sub_out_valid", out_valid, 1);
    check("sub_out_sum", out_sum, 2);
    check("sub_out_flags", out_flags, 0);
    check("sub_acc", acc, 2);
    check("sub_cnt", res_cnt, 1);
    out_ready = 1'b1;
    tick(1);

    // borrow (5-6) then zero (5-5)
    push(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef ADDSUB_FLAGS_EN
    check("borrow_flags", out_flags, 2);
`else
    check("borrow_flags", out_flags, 0);
`endif
    check("borrow_sum", out_sum, 15);
    out_ready = 1'b1;
    tick(1);
    push(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef ADDSUB_FLAGS_EN
    check("zero_flags", out_flags, 1);
`else
    check("zero_flags", out_flags, 0);
`endif
    check("zero_cout", out_cout, 1);
    check("flag_acc", acc, 17);
    out_ready = 1'b1;
    tick(1);

    // fill to full, then a push alongside a pop must be refused
    for (int i = 1; i <= DEPTH; i++) push(4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    check("full_in_ready", in_ready, 0);
    push(4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    out_ready = 1'b0;
    check("full_cnt", res_cnt, 7);
    check("after_pop_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick(DEPTH + 1);

    // accumulator wrap and clear-with-push
    acc_clr = 1'b1;
    tick(1);
    acc_clr = 1'b0;
    check("clr_acc", acc, 0);
    for (int i = 1; i <= 16; i++) begin
      push(4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);
      if (i == 8) begin
        check("acc8", acc, 248);
        check("ovf8", acc_ovf, 0);
      end
      if (i == 9) begin
        check("acc9", acc, 23);
        check("ovf9", acc_ovf, 1);
      end
    end
    check("acc16", acc, 240);
    check("ovf16", acc_ovf, 1);
    push(4'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    check("clrpush_acc", acc, 3);
    check("clrpush_ovf", acc_ovf, 0);
    check("clrpush_cnt", res_cnt, 1);

    // counter saturation
    for (int i = 0; i < 258; i++) push(4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("cnt_sat", res_cnt, 255);
    tick(2);

    // asynchronous reset with entries queued
    for (int i = 0; i < 3; i++) push(4'(i + 5), 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_acc", acc, 0);
    check("arst_cnt", res_cnt, 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check("arst_in_ready", in_ready, 1);
    check("arst_empty", out_valid, 0);

    // random traffic
    repeat (400) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_sum    = 4'($urandom_range(0, 15));
      in_cout   = 1'($urandom_range(0, 1));
      in_op     = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      acc_clr   = ($urandom_range(0, 24) == 0);
      tick(1);
    end
    in_valid  = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    tick(DEPTH + 2);
    check("drain_out_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
